// File: rtl/aes_subbytes_serial.sv
// rtl/aes_subbytes_serial.sv - byte-serial AES SubBytes stage feeding ShiftRows
//
// Substitutes a 128-bit AES state BYTES_PER_CYCLE bytes per clock through shared
// S-box logic. It takes NUM_STEPS = 16/BYTES_PER_CYCLE clocks per state.
// Optional macro AES_INV_SUBBYTES_EN adds inverse S-boxes, selected by the inv
// value latched at accept.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   state_in is valid
//   in_ready   block can accept a state this cycle
//   state_in   128-bit input state, byte k = state_in[127-8k -: 8]
//   inv        1 = InvSubBytes (only with AES_INV_SUBBYTES_EN), latched at accept
//   out_valid  state_out holds a complete result
//   out_ready  downstream accepts the result
//   state_out  substituted state, registered
//   busy       high while a substitution run is in progress

module aes_subbytes_serial #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int SW        = 8 * BYTES_PER_CYCLE;

    generate
        if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
            BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
            $error("aes_subbytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
               {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

`ifdef AES_INV_SUBBYTES_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t           fsm, fsm_next;
    logic [CW-1:0]  step;
    logic [127:0]   work;
    logic [127:0]   work_next;
    logic [SW-1:0]  sub_top;
    logic           last_step;
    logic           accept;

`ifdef AES_INV_SUBBYTES_EN
    logic           inv_q;
`else
    logic           unused_inv;
    assign unused_inv = inv;
`endif

    assign last_step = (step == CW'(NUM_STEPS - 1));
    assign in_ready  = (fsm == IDLE) || (fsm == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == RUN);

    // The working register rotates left by one step's worth of bytes per clock,
    // so the bytes due for substitution are always the top ones. After
    // NUM_STEPS rotations every byte is back in its original position.
    always_comb begin
        sub_top = '0;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
`ifdef AES_INV_SUBBYTES_EN
            sub_top[SW-1-8*j -: 8] = inv_q ? inv_sbox(work[127-8*j -: 8])
                                           : fwd_sbox(work[127-8*j -: 8]);
`else
            sub_top[SW-1-8*j -: 8] = fwd_sbox(work[127-8*j -: 8]);
`endif
        end
    end

    logic [127+SW:0] rot_cat;
    assign rot_cat   = {work, sub_top};
    assign work_next = rot_cat[127:0];

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_next = RUN;
            RUN:     if (last_step) fsm_next = DONE;
            DONE:    if (out_ready) fsm_next = in_valid ? RUN : IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            step      <= '0;
            work      <= '0;
            state_out <= '0;
`ifdef AES_INV_SUBBYTES_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            fsm <= fsm_next;
            if (accept) begin
                work <= state_in;
                step <= '0;
`ifdef AES_INV_SUBBYTES_EN
                inv_q <= inv;
`endif
            end else if (fsm == RUN) begin
                work <= work_next;
                step <= step + CW'(1);
                if (last_step) state_out <= work_next;
            end
        end
    end

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// tb/tb_aes_subbytes_serial.sv - randomized self-checking bench for aes_subbytes_serial

module tb_aes_subbytes_serial;

    localparam int NS = 16;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, inv, out_valid, out_ready, busy;
    logic [127:0] state_in, state_out;

    logic         iv_w, ordy_w;
    logic [127:0] sin_w;
    logic         ir4, ov4, busy4, ir16, ov16, busy16;
    logic [127:0] so4, so16;

    always #5 clk = ~clk;

    aes_subbytes_serial dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .inv(inv), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy));

    aes_subbytes_serial #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv_w), .in_ready(ir4),
        .state_in(sin_w), .inv(1'b0), .out_valid(ov4), .out_ready(ordy_w),
        .state_out(so4), .busy(busy4));

    aes_subbytes_serial #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv_w), .in_ready(ir16),
        .state_in(sin_w), .inv(1'b0), .out_valid(ov16), .out_ready(ordy_w),
        .state_out(so16), .busy(busy16));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic ii);
        logic [127:0] r;
        logic         use_inv;
`ifdef AES_INV_SUBBYTES_EN
        use_inv = ii;
`else
        use_inv = 1'b0;
        if (ii) use_inv = 1'b0;
`endif
        for (int k = 0; k < 16; k++)
            r[127-8*k -: 8] = use_inv ? isbox[d[127-8*k -: 8]] : sbox[d[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: apply inputs, check outputs against the transaction model, step the model
    task automatic cycle(input logic iv, input logic [127:0] d, input logic ii,
                         input logic ordy, input logic r, output logic accepted);
        logic exp_ov, exp_busy, exp_ir, inflight;
        in_valid = iv; state_in = d; inv = ii; out_ready = ordy; rst = r;
        #1;
        inflight = (q.size() > 0);
        exp_ov   = inflight && (cyc - acc_cyc) >= NS;
        exp_busy = inflight && (cyc - acc_cyc) < NS;
        exp_ir   = !inflight || (exp_ov && ordy);
        check("out_valid", 128'(out_valid), 128'(exp_ov));
        check("busy", 128'(busy), 128'(exp_busy));
        check("in_ready", 128'(in_ready), 128'(exp_ir));
        if (exp_ov) check("state_out", state_out, q[0]);
        accepted = 1'b0;
        if (r) begin
            q.delete();
        end else begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (iv && exp_ir) begin
                q.push_back(model(d, ii));
                acc_cyc  = cyc + 1;
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         a;
        logic [127:0] held, vl[3];
        int           lat4, lat16, i, guard, prev;

        for (int n = 0; n < 256; n++) begin
            sbox[n] = SBOX_HEX[2047-8*n -: 8];
            isbox[sbox[n]] = 8'(n);
        end

        rst = 1'b1; in_valid = 1'b0; state_in = '0; inv = 1'b0; out_ready = 1'b0;
        iv_w = 1'b0; sin_w = '0; ordy_w = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #1;
        check("rst_state_out", state_out, 128'h0);
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_in_ready", 128'(in_ready), 128'h1);

        // Wider datapaths: latency 16/BYTES_PER_CYCLE
        iv_w = 1'b1; sin_w = {16{8'hff}};
        @(posedge clk); #1; iv_w = 1'b0;
        lat4 = -1; lat16 = -1;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            if (ov4 && lat4 < 0) lat4 = t;
            if (ov16 && lat16 < 0) lat16 = t;
        end
        check("bpc4_latency", 128'(lat4), 128'd4);
        check("bpc16_latency", 128'(lat16), 128'd1);
        check("bpc4_data", so4, {16{8'h16}});
        check("bpc16_data", so16, {16{8'h16}});
        ordy_w = 1'b1;

        // Known-answer vector
        cycle(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b0, a);
        for (int t = 0; t < NS; t++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
        check("kat_valid", 128'(out_valid), 128'h1);
        check("kat_busy", 128'(busy), 128'h0);
        check("kat_data", state_out, 128'h638293c31bfc33f5c4eeacea4bc12816);

        // Hold in DONE with a waiting new state, then handoff + accept on one edge
        held = rand128();
        for (int t = 0; t < 5; t++) begin
            cycle(1'b1, held, 1'b0, 1'b0, 1'b0, a);
            check("hold_data", state_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
        end
        cycle(1'b1, held, 1'b0, 1'b1, 1'b0, a);
        check("handoff_accept", 128'(a), 128'h1);
        check("handoff_busy", 128'(busy), 128'h1);
        prev = acc_cyc;

        // Back-to-back stream: one state per NS+1 clocks
        vl[0] = {16{8'h53}}; vl[1] = rand128(); vl[2] = rand128();
        i = 0; guard = 0;
        while (i < 3 && guard < 200) begin
            cycle(1'b1, vl[i], 1'b0, 1'b1, 1'b0, a);
            if (a) begin
                check("b2b_period", 128'(acc_cyc - prev), 128'(NS + 1));
                prev = acc_cyc;
                i++;
            end
            guard++;
        end
        check("b2b_done", 128'(i), 128'd3);
        guard = 0;
        while (q.size() > 0 && guard < 60) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
            guard++;
        end
        check("b2b_drain", 128'(q.size()), 128'd0);

        // Reset at RUN step 7 discards the run
        cycle(1'b1, rand128(), 1'b0, 1'b0, 1'b0, a);
        for (int t = 0; t < 7; t++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        check("midrst_valid", 128'(out_valid), 128'h0);
        check("midrst_data", state_out, 128'h0);
        check("midrst_ready", 128'(in_ready), 128'h1);

        // Inverse path (or forward result without the feature)
        cycle(1'b1, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 1'b0, 1'b0, a);
        for (int t = 0; t < NS; t++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
`ifdef AES_INV_SUBBYTES_EN
        check("inv_kat", state_out, 128'h00112233445566778899aabbccddeeff);
`else
        check("inv_ignored", state_out, model(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0));
`endif
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2500; n++)
            cycle(1'($urandom_range(0, 1)), rand128(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 399) == 0), a);
        guard = 0;
        while (q.size() > 0 && guard < 60) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
            guard++;
        end
        check("final_drain", 128'(q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
